alu_imm_iq: RTL and testbench



---
 rtl/alu_imm_iq_if.sv | 60 ++++++
 rtl/alu_imm_iq.sv | 169 ++++++++++++++++
 tb/tb_alu_imm_iq.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_imm_iq_if.sv
// Dispatch, wakeup, issue and PRF-request signals of the reg-imm ALU issue queue.
// slave: the issue queue itself; master: the surrounding dispatch/pipeline side.
interface alu_imm_iq_if #(
    parameter int LOG_PR_COUNT       = 7,
    parameter int LOG_PRF_BANK_COUNT = 2,
    parameter int PRF_BANK_COUNT     = 4,
    parameter int LOG_ROB_ENTRIES    = 6
);
    localparam int UPW = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;

    // dispatch
    logic                       dispatch_valid;
    logic [3:0]                 dispatch_op;
    logic [11:0]                dispatch_imm12;
    logic [LOG_PR_COUNT-1:0]    dispatch_A_PR;
    logic                       dispatch_A_ready;
    logic                       dispatch_A_is_zero;
    logic [LOG_PR_COUNT-1:0]    dispatch_dest_PR;
    logic [LOG_ROB_ENTRIES-1:0] dispatch_ROB_index;
    logic                       dispatch_ack;

    // writeback wakeup
    logic [PRF_BANK_COUNT-1:0]           WB_bus_valid_by_bank;
    logic [PRF_BANK_COUNT-1:0][UPW-1:0]  WB_bus_upper_PR_by_bank;

    logic                       flush;

    // issue
    logic                          issue_ready;
    logic                          issue_valid;
    logic [3:0]                    issue_op;
    logic [11:0]                   issue_imm12;
    logic                          issue_A_forward;
    logic                          issue_A_is_zero;
    logic [LOG_PRF_BANK_COUNT-1:0] issue_A_bank;
    logic [LOG_PR_COUNT-1:0]       issue_dest_PR;
    logic [LOG_ROB_ENTRIES-1:0]    issue_ROB_index;

    // PRF read request
    logic                       PRF_req_A_valid;
    logic [LOG_PR_COUNT-1:0]    PRF_req_A_PR;

    modport slave (
        input  dispatch_valid, dispatch_op, dispatch_imm12, dispatch_A_PR, dispatch_A_ready,
               dispatch_A_is_zero, dispatch_dest_PR, dispatch_ROB_index,
               WB_bus_valid_by_bank, WB_bus_upper_PR_by_bank, flush, issue_ready,
        output dispatch_ack, issue_valid, issue_op, issue_imm12, issue_A_forward,
               issue_A_is_zero, issue_A_bank, issue_dest_PR, issue_ROB_index,
               PRF_req_A_valid, PRF_req_A_PR
    );

    modport master (
        output dispatch_valid, dispatch_op, dispatch_imm12, dispatch_A_PR, dispatch_A_ready,
               dispatch_A_is_zero, dispatch_dest_PR, dispatch_ROB_index,
               WB_bus_valid_by_bank, WB_bus_upper_PR_by_bank, flush, issue_ready,
        input  dispatch_ack, issue_valid, issue_op, issue_imm12, issue_A_forward,
               issue_A_is_zero, issue_A_bank, issue_dest_PR, issue_ROB_index,
               PRF_req_A_valid, PRF_req_A_PR
    );
endinterface

// File: rtl/alu_imm_iq.sv
// Issue queue for reg-imm ALU ops. Collapsing array: valid entries occupy
// indices 0..count-1 in age order, so the oldest ready op is simply the
// lowest-index ready entry. Issues at most one op per cycle, registered.
module alu_imm_iq #(
    parameter int IQ_ENTRIES         = 8,
    parameter int LOG_PR_COUNT       = 7,
    parameter int LOG_PRF_BANK_COUNT = 2,
    parameter int PRF_BANK_COUNT     = 4,
    parameter int LOG_ROB_ENTRIES    = 6
) (
    input  logic         CLK,
    input  logic         RST,
    alu_imm_iq_if.slave  bus
);
    localparam int UPW = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;
    localparam int CW  = $clog2(IQ_ENTRIES + 1);
    localparam int IW  = $clog2(IQ_ENTRIES);

    typedef struct packed {
        logic [3:0]                 op;
        logic [11:0]                imm12;
        logic [LOG_PR_COUNT-1:0]    a_pr;
        logic                       a_ready;
        logic                       a_is_zero;
        logic [LOG_PR_COUNT-1:0]    dest_pr;
        logic [LOG_ROB_ENTRIES-1:0] rob_index;
    } entry_t;

    entry_t entry_q [IQ_ENTRIES];
    entry_t entry_d [IQ_ENTRIES];
    entry_t upd     [IQ_ENTRIES];   // entries with this cycle's wakeups folded in

    logic [IQ_ENTRIES-1:0] woken, issuable;
    logic [CW-1:0]         count_q, count_d, wr_idx;
    logic [IW-1:0]         sel_idx;
    logic                  sel_found, sel_woken, fire, ack, accept;
    entry_t                sel_e, new_e;

    logic                          issue_valid_q, issue_valid_d;
    logic [3:0]                    issue_op_q, issue_op_d;
    logic [11:0]                   issue_imm12_q, issue_imm12_d;
    logic                          issue_fwd_q, issue_fwd_d;
    logic                          issue_zero_q, issue_zero_d;
    logic [LOG_PRF_BANK_COUNT-1:0] issue_bank_q, issue_bank_d;
    logic [LOG_PR_COUNT-1:0]       issue_dest_q, issue_dest_d;
    logic [LOG_ROB_ENTRIES-1:0]    issue_rob_q, issue_rob_d;
    logic                          prf_valid_q, prf_valid_d;
    logic [LOG_PR_COUNT-1:0]       prf_pr_q, prf_pr_d;

    // A source PR is being written back this cycle if its bank's WB slot carries its upper bits
    function automatic logic wakes(input logic [LOG_PR_COUNT-1:0]           pr,
                                   input logic [PRF_BANK_COUNT-1:0]          v,
                                   input logic [PRF_BANK_COUNT-1:0][UPW-1:0] u);
        logic [LOG_PRF_BANK_COUNT-1:0] b;
        b = pr[LOG_PRF_BANK_COUNT-1:0];
        return v[b] && (u[b] == pr[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT]);
    endfunction

    // Wakeup per entry and oldest-ready select
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < IQ_ENTRIES; i++) begin
            woken[i]    = wakes(entry_q[i].a_pr, bus.WB_bus_valid_by_bank, bus.WB_bus_upper_PR_by_bank);
            issuable[i] = (CW'(i) < count_q) &&
                          (entry_q[i].a_ready || entry_q[i].a_is_zero || woken[i]);
            upd[i]         = entry_q[i];
            upd[i].a_ready = entry_q[i].a_ready | woken[i];
        end
        for (int i = IQ_ENTRIES - 1; i >= 0; i--) begin
            if (issuable[i]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
        end
    end

    // Handshake, queue update (collapse + append) and issue register inputs
    always_comb begin
        ack    = !RST && (count_q < CW'(IQ_ENTRIES));
        fire   = sel_found && bus.issue_ready && !bus.flush;
        accept = bus.dispatch_valid && ack && !bus.flush;

        sel_e     = '0;
        sel_woken = 1'b0;
        for (int i = 0; i < IQ_ENTRIES; i++) begin
            if (IW'(i) == sel_idx) begin
                sel_e     = entry_q[i];
                sel_woken = woken[i];
            end
        end

        new_e.op        = bus.dispatch_op;
        new_e.imm12     = bus.dispatch_imm12;
        new_e.a_pr      = bus.dispatch_A_PR;
        // a wakeup in the arrival cycle must not be lost
        new_e.a_ready   = bus.dispatch_A_ready |
                          wakes(bus.dispatch_A_PR, bus.WB_bus_valid_by_bank, bus.WB_bus_upper_PR_by_bank);
        new_e.a_is_zero = bus.dispatch_A_is_zero;
        new_e.dest_pr   = bus.dispatch_dest_PR;
        new_e.rob_index = bus.dispatch_ROB_index;

        for (int i = 0; i < IQ_ENTRIES; i++) entry_d[i] = upd[i];
        for (int i = 0; i < IQ_ENTRIES - 1; i++) begin
            if (fire && (IW'(i) >= sel_idx)) entry_d[i] = upd[i+1];
        end
        // append after the collapse so the new op lands right above the survivors
        wr_idx = count_q - CW'(fire);
        for (int i = 0; i < IQ_ENTRIES; i++) begin
            if (accept && (CW'(i) == wr_idx)) entry_d[i] = new_e;
        end

        count_d = bus.flush ? '0 : (count_q - CW'(fire) + CW'(accept));

        issue_valid_d = fire;
        issue_op_d    = fire ? sel_e.op : '0;
        issue_imm12_d = fire ? sel_e.imm12 : '0;
        issue_fwd_d   = fire && sel_woken && !sel_e.a_ready && !sel_e.a_is_zero;
        issue_zero_d  = fire && sel_e.a_is_zero;
        issue_bank_d  = fire ? sel_e.a_pr[LOG_PRF_BANK_COUNT-1:0] : '0;
        issue_dest_d  = fire ? sel_e.dest_pr : '0;
        issue_rob_d   = fire ? sel_e.rob_index : '0;
        prf_valid_d   = fire && !issue_fwd_d && !sel_e.a_is_zero;
        prf_pr_d      = fire ? sel_e.a_pr : '0;
    end

    // State and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < IQ_ENTRIES; i++) entry_q[i] <= '0;
            count_q       <= '0;
            issue_valid_q <= 1'b0;
            issue_op_q    <= '0;
            issue_imm12_q <= '0;
            issue_fwd_q   <= 1'b0;
            issue_zero_q  <= 1'b0;
            issue_bank_q  <= '0;
            issue_dest_q  <= '0;
            issue_rob_q   <= '0;
            prf_valid_q   <= 1'b0;
            prf_pr_q      <= '0;
        end else begin
            for (int i = 0; i < IQ_ENTRIES; i++) entry_q[i] <= entry_d[i];
            count_q       <= count_d;
            issue_valid_q <= issue_valid_d;
            issue_op_q    <= issue_op_d;
            issue_imm12_q <= issue_imm12_d;
            issue_fwd_q   <= issue_fwd_d;
            issue_zero_q  <= issue_zero_d;
            issue_bank_q  <= issue_bank_d;
            issue_dest_q  <= issue_dest_d;
            issue_rob_q   <= issue_rob_d;
            prf_valid_q   <= prf_valid_d;
            prf_pr_q      <= prf_pr_d;
        end
    end

    assign bus.dispatch_ack    = ack;
    assign bus.issue_valid     = issue_valid_q;
    assign bus.issue_op        = issue_op_q;
    assign bus.issue_imm12     = issue_imm12_q;
    assign bus.issue_A_forward = issue_fwd_q;
    assign bus.issue_A_is_zero = issue_zero_q;
    assign bus.issue_A_bank    = issue_bank_q;
    assign bus.issue_dest_PR   = issue_dest_q;
    assign bus.issue_ROB_index = issue_rob_q;
    assign bus.PRF_req_A_valid = prf_valid_q;
    assign bus.PRF_req_A_PR    = prf_pr_q;
endmodule

// File: tb/tb_alu_imm_iq.sv
// Bench for alu_imm_iq: directed scenarios plus random traffic. The driver runs
// an age-ordered queue model each cycle and pushes expected issues (stamped with
// the cycle they must appear) into a scoreboard; a negedge monitor checks them.
module tb_alu_imm_iq;
    localparam int N     = 8;
    localparam int PRW   = 7;
    localparam int LB    = 2;
    localparam int BANKS = 4;
    localparam int ROBW  = 6;
    localparam int UW    = PRW - LB;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    alu_imm_iq_if #(.LOG_PR_COUNT(PRW), .LOG_PRF_BANK_COUNT(LB), .PRF_BANK_COUNT(BANKS),
                    .LOG_ROB_ENTRIES(ROBW)) bus ();
    alu_imm_iq #(.IQ_ENTRIES(N), .LOG_PR_COUNT(PRW), .LOG_PRF_BANK_COUNT(LB),
                 .PRF_BANK_COUNT(BANKS), .LOG_ROB_ENTRIES(ROBW)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    typedef struct {
        bit dv; logic [3:0] op; logic [11:0] imm; int apr; bit ard; bit az;
        logic [PRW-1:0] dst; logic [ROBW-1:0] rob;
        logic [BANKS-1:0] wbv; logic [BANKS-1:0][UW-1:0] wbu; bit fl; bit ir;
    } stim_t;
    typedef struct {
        logic [3:0] op; logic [11:0] imm; int pr; bit rdy; bit zero;
        logic [PRW-1:0] dest; logic [ROBW-1:0] rob;
    } ment_t;
    typedef struct {
        int cyc; logic [3:0] op; logic [11:0] imm; bit fwd; bit zero;
        logic [PRW-1:0] dest; logic [ROBW-1:0] rob; bit prfv; int pr;
    } exp_t;

    ment_t mq[$];
    exp_t  eq[$];
    int    n_vec = 0;
    int    n_fail = 0;
    int    cyc = 0;
    stim_t s;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic bit wk(input int pr, input logic [BANKS-1:0] v, input logic [BANKS-1:0][UW-1:0] u);
        return v[pr % BANKS] && (int'(u[pr % BANKS]) == pr / BANKS);
    endfunction

    function automatic stim_t idle(input bit ir);
        stim_t t;
        t.dv = 0; t.op = '0; t.imm = '0; t.apr = 0; t.ard = 0; t.az = 0; t.dst = '0; t.rob = '0;
        t.wbv = '0; t.wbu = '0; t.fl = 0; t.ir = ir;
        return t;
    endfunction

    function automatic stim_t rnd();
        stim_t t;
        t.dv  = ($urandom_range(0, 9) < 6);
        t.op  = 4'($urandom_range(0, 15));
        t.imm = 12'($urandom_range(0, 4095));
        t.apr = $urandom_range(0, 15);
        t.ard = ($urandom_range(0, 9) < 3);
        t.az  = ($urandom_range(0, 9) == 0);
        t.dst = PRW'($urandom_range(0, 127));
        t.rob = ROBW'($urandom_range(0, 63));
        for (int b = 0; b < BANKS; b++) begin
            t.wbv[b] = ($urandom_range(0, 9) < 2);
            t.wbu[b] = UW'($urandom_range(0, 3));
        end
        t.fl = ($urandom_range(0, 49) == 0);
        t.ir = ($urandom_range(0, 3) != 0);
        return t;
    endfunction

    function automatic logic [40:0] pack_exp(input exp_t x);
        return {x.op, x.imm, x.fwd, x.zero, LB'(x.pr % BANKS), x.dest, x.rob, x.prfv, PRW'(x.pr)};
    endfunction

    task automatic drive_idle();
        bus.dispatch_valid = 0; bus.dispatch_op = '0; bus.dispatch_imm12 = '0; bus.dispatch_A_PR = '0;
        bus.dispatch_A_ready = 0; bus.dispatch_A_is_zero = 0; bus.dispatch_dest_PR = '0;
        bus.dispatch_ROB_index = '0; bus.WB_bus_valid_by_bank = '0; bus.WB_bus_upper_PR_by_bank = '0;
        bus.flush = 0; bus.issue_ready = 0;
    endtask

    // one cycle: check ack, drive inputs, advance the model
    task automatic step(input stim_t t);
        int    size0, idx;
        exp_t  x;
        ment_t m;
        @(posedge CLK); #1;
        n_vec++;
        if (bus.dispatch_ack !== (mq.size() < N)) begin
            n_fail++;
            $display("FAIL dispatch_ack cyc=%0d got=%b exp=%b (model count %0d)", cyc, bus.dispatch_ack, mq.size() < N, mq.size());
        end
        bus.dispatch_valid = t.dv; bus.dispatch_op = t.op; bus.dispatch_imm12 = t.imm;
        bus.dispatch_A_PR = PRW'(t.apr); bus.dispatch_A_ready = t.ard; bus.dispatch_A_is_zero = t.az;
        bus.dispatch_dest_PR = t.dst; bus.dispatch_ROB_index = t.rob;
        bus.WB_bus_valid_by_bank = t.wbv; bus.WB_bus_upper_PR_by_bank = t.wbu;
        bus.flush = t.fl; bus.issue_ready = t.ir;

        size0 = mq.size();
        idx = -1;
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].rdy || mq[i].zero || wk(mq[i].pr, t.wbv, t.wbu)) begin idx = i; break; end
        end
        if (t.ir && !t.fl && idx >= 0) begin
            m = mq[idx];
            x.cyc = cyc + 1; x.op = m.op; x.imm = m.imm; x.zero = m.zero; x.dest = m.dest; x.rob = m.rob;
            x.fwd = wk(m.pr, t.wbv, t.wbu) && !m.rdy && !m.zero;
            x.prfv = !x.fwd && !m.zero; x.pr = m.pr;
            eq.push_back(x);
            mq.delete(idx);
        end
        foreach (mq[i]) if (wk(mq[i].pr, t.wbv, t.wbu)) mq[i].rdy = 1;
        if (t.fl) mq.delete();
        else if (t.dv && size0 < N) begin
            m.op = t.op; m.imm = t.imm; m.pr = t.apr; m.rdy = t.ard || wk(t.apr, t.wbv, t.wbu);
            m.zero = t.az; m.dest = t.dst; m.rob = t.rob;
            mq.push_back(m);
        end
    endtask

    task automatic check_out_zero(input string nm);
        n_vec++;
        if ({bus.issue_valid, bus.PRF_req_A_valid, bus.dispatch_ack, bus.issue_op, bus.issue_A_forward} !== '0) begin
            n_fail++;
            $display("FAIL %s got issue_valid=%b prf_valid=%b ack=%b op=%h fwd=%b exp all 0", nm,
                     bus.issue_valid, bus.PRF_req_A_valid, bus.dispatch_ack, bus.issue_op, bus.issue_A_forward);
        end
    endtask

    // scoreboard monitor
    always @(negedge CLK) begin
        exp_t x;
        if (RST !== 1'b1) begin
            while (eq.size() > 0 && eq[0].cyc < cyc) begin
                x = eq.pop_front();
                n_vec++; n_fail++;
                $display("FAIL missed_issue cyc=%0d exp op=%h imm=%h at cyc %0d", cyc, x.op, x.imm, x.cyc);
            end
            n_vec++;
            if (bus.issue_valid) begin
                if (eq.size() == 0 || eq[0].cyc != cyc) begin
                    n_fail++;
                    $display("FAIL unexpected_issue cyc=%0d got op=%h imm=%h exp none", cyc, bus.issue_op, bus.issue_imm12);
                end else begin
                    x = eq.pop_front();
                    if ({bus.issue_op, bus.issue_imm12, bus.issue_A_forward, bus.issue_A_is_zero, bus.issue_A_bank,
                         bus.issue_dest_PR, bus.issue_ROB_index, bus.PRF_req_A_valid, bus.PRF_req_A_PR} !== pack_exp(x)) begin
                        n_fail++;
                        $display("FAIL issue_fields cyc=%0d got=%h exp=%h", cyc,
                                 {bus.issue_op, bus.issue_imm12, bus.issue_A_forward, bus.issue_A_is_zero, bus.issue_A_bank,
                                  bus.issue_dest_PR, bus.issue_ROB_index, bus.PRF_req_A_valid, bus.PRF_req_A_PR}, pack_exp(x));
                    end
                end
            end else if (bus.PRF_req_A_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL prf_req_without_issue cyc=%0d got=%b exp=0", cyc, bus.PRF_req_A_valid);
            end
        end
    end

    initial begin
        RST = 1;
        drive_idle();
        repeat (3) @(posedge CLK);
        #1 check_out_zero("reset_state");
        RST = 0;
        #1;
        n_vec++;
        if (bus.dispatch_ack !== 1'b1) begin
            n_fail++; $display("FAIL ack_after_reset got=%b exp=1", bus.dispatch_ack);
        end

        // ready op issues two cycles after dispatch, via PRF
        s = idle(1); s.dv = 1; s.op = 4; s.imm = 12'h123; s.apr = 9; s.ard = 1; s.dst = 7'd5; s.rob = 6'd3;
        step(s);
        repeat (3) step(idle(1));

        // not-ready op woken three cycles later -> forwarded
        s = idle(1); s.dv = 1; s.op = 2; s.imm = 12'h0aa; s.apr = 17; s.dst = 7'd6; s.rob = 6'd4;
        step(s);
        repeat (2) step(idle(1));
        s = idle(1); s.wbv[17 % BANKS] = 1; s.wbu[17 % BANKS] = UW'(17 / BANKS);
        step(s);
        repeat (2) step(idle(1));

        // fill, overflow attempt, wake the entry at index 5, then collapse
        for (int i = 0; i < N + 1; i++) begin
            s = idle(1); s.dv = 1; s.op = 4'(i); s.imm = 12'(16'h100 + i); s.apr = 16 + i;
            s.dst = PRW'(i); s.rob = ROBW'(i);
            step(s);
        end
        s = idle(1); s.wbv[21 % BANKS] = 1; s.wbu[21 % BANKS] = UW'(21 / BANKS);
        step(s);
        repeat (2) step(idle(1));
        s = idle(1); s.dv = 1; s.op = 4'hf; s.apr = 30; s.ard = 1;   // refills the freed slot
        step(s);
        repeat (2) step(idle(1));
        s = idle(1); s.fl = 1;
        step(s);

        // two ready ops held back, then issued oldest first
        for (int i = 0; i < 2; i++) begin
            s = idle(0); s.dv = 1; s.op = 4'(8 + i); s.imm = 12'(i); s.apr = 40 + i; s.ard = 1;
            step(s);
        end
        repeat (3) step(idle(0));
        repeat (3) step(idle(1));

        // x0 source issues without wakeup
        s = idle(1); s.dv = 1; s.op = 4'h7; s.apr = 0; s.az = 1;
        step(s);
        repeat (2) step(idle(1));

        // flush with a ready dispatch in the same cycle
        for (int i = 0; i < 5; i++) begin
            s = idle(1); s.dv = 1; s.op = 4'(i); s.apr = 50 + i;
            step(s);
        end
        s = idle(1); s.dv = 1; s.op = 4'h3; s.apr = 60; s.ard = 1; s.fl = 1;
        step(s);
        repeat (3) step(idle(1));

        // random traffic
        for (int k = 0; k < 600; k++) step(rnd());
        s = idle(1); s.fl = 1;
        step(s);
        repeat (3) step(idle(1));

        // asynchronous reset while an issue is being presented
        s = idle(1); s.dv = 1; s.op = 4'h9; s.apr = 3; s.ard = 1;
        step(s);
        step(idle(1));
        @(posedge CLK); #2;
        n_vec++;
        if (bus.issue_valid !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_issue got=%b exp=1", bus.issue_valid);
        end
        eq.delete(); mq.delete();
        drive_idle();
        RST = 1;
        #1 check_out_zero("async_reset");
        @(posedge CLK); #1;
        RST = 0;
        repeat (4) step(rnd());
        repeat (3) step(idle(1));
        s = idle(1); s.fl = 1;
        step(s);
        repeat (2) step(idle(1));

        @(negedge CLK); #1;
        n_vec++;
        if (eq.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain got=%0d pending exp=0", eq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
